dmem_mmio_responder: RTL and testbench

DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

---
 rtl/dmem_mmio_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Data-memory responder for a processor memory stage. Decodes a 32-bit word
//   address into a data RAM, a free-running cycle counter, and a transmit
//   FIFO with its status register.
//
//   Address map:
//     0 .. RAM_WORDS-1  data RAM (read/write)
//     0x1000            CYCLE   (read-only free-running counter)
//     0x1001            TXDATA  (store pushes into FIFO, load returns 0)
//     0x1002            STATUS  (read count/flags, any store clears overflow)
//     everything else   unmapped (loads return 0, stores ignored)
//
//   Ports:
//     clock         single clock, rising-edge
//     reset         asynchronous active-high reset
//     address_dmem  word address
//     data          store data
//     wren          store enable
//     q_dmem        registered load data (one-cycle latency)
//     out_valid     FIFO head valid
//     out_ready     downstream consumer ready
//     out_data      FIFO head word (0 when empty)
module dmem_mmio_responder #(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    localparam logic [31:0] ADDR_CYCLE  = 32'h0000_1000;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_1001;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_1002;

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] fifo_mem [FIFO_DEPTH];

    logic [31:0]     cycle_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic            sel_ram;
    logic            sel_cycle;
    logic            sel_txdata;
    logic            sel_status;
    logic [RAM_AW-1:0] ram_idx;
    logic            store_ok;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            overflow_next;
    logic [3:0]      cnt_field;
    logic [31:0]     rd_data;
    logic [PW-1:0]   wr_ptr_inc;
    logic [PW-1:0]   rd_ptr_inc;

    assign sel_ram    = (address_dmem < 32'(RAM_WORDS));
    assign sel_cycle  = (address_dmem == ADDR_CYCLE);
    assign sel_txdata = (address_dmem == ADDR_TXDATA);
    assign sel_status = (address_dmem == ADDR_STATUS);
    assign ram_idx    = address_dmem[RAM_AW-1:0];

    // Stores seen while reset is held must not touch RAM or the FIFO.
    assign store_ok = wren && !reset;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : fifo_mem[rd_ptr];

    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign pop      = out_valid && out_ready;
    assign push_req = store_ok && sel_txdata;
    assign push     = push_req && (!full || pop);

    // Clear-on-store loses to a concurrent dropped push.
    assign overflow_next = ((store_ok && sel_status) ? 1'b0 : overflow)
                         | (push_req && !push);

    assign cnt_field = 4'(count);

    assign wr_ptr_inc = (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_comb begin
        rd_data = 32'd0;
        if (sel_ram) begin
            rd_data = ram[ram_idx];
        end else if (sel_cycle) begin
            rd_data = cycle_cnt;
        end else if (sel_status) begin
            rd_data = {24'd0, cnt_field, 1'b0, overflow, full, empty};
        end
    end

    // RAM has no reset; the non-blocking write gives read-old-data on a
    // same-address same-edge store.
    always_ff @(posedge clock) begin
        if (store_ok && sel_ram) begin
            ram[ram_idx] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_dmem    <= 32'd0;
            cycle_cnt <= 32'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            q_dmem    <= rd_data;
            cycle_cnt <= cycle_cnt + 32'd1;
            overflow  <= overflow_next;
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] exp;

    dmem_mmio_responder #(.RAM_WORDS(4096), .FIFO_DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(32'h1000, 32'd0, 1'b0);
        tick();
        total++; if (q_dmem !== 32'd0) begin bad++; $display("FAIL reset_q got=%h want=%h", q_dmem, 32'd0); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            exp_q.push_back(32'(i - 1));
            tick();
            exp = exp_q.pop_front();
            if (i == 1 || i == 10) begin
                total++; if (q_dmem !== exp) begin bad++; $display("FAIL cycle_after_reset edge=%0d got=%h want=%h", i, q_dmem, exp); end
            end
        end
    endtask

    task automatic test_ram();
        drive(32'h0005, 32'hDEAD_BEEF, 1'b1);
        tick();
        drive(32'h0005, 32'd0, 1'b0);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL ram_load got=%h want=%h", q_dmem, exp); end
    endtask

    task automatic test_same_edge();
        drive(32'h0007, 32'h22, 1'b1);
        tick();
        drive(32'h0007, 32'h11, 1'b1);
        exp_q.push_back(32'h22);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL same_edge_old got=%h want=%h", q_dmem, exp); end
        drive(32'h0007, 32'd0, 1'b0);
        exp_q.push_back(32'h11);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL same_edge_new got=%h want=%h", q_dmem, exp); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            drive(32'h1001, 32'(v), 1'b1);
            if (fifo_q.size() < 4) fifo_q.push_back(32'(v));
            tick();
        end
        drive(32'h1002, 32'd0, 1'b0);
        exp_q.push_back(32'h46);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL status_overflow got=%h want=%h", q_dmem, exp); end
        out_ready = 1'b1;
        drive(32'h0000, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp = fifo_q.pop_front();
            total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL drain_ovf idx=%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp); end
            tick();
        end
        total++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin bad++; $display("FAIL drain_ovf_empty got=%b/%h want=0/0", out_valid, out_data); end
        out_ready = 1'b0;
        drive(32'h1002, 32'd0, 1'b1);
        tick();
        drive(32'h1002, 32'd0, 1'b0);
        exp_q.push_back(32'h01);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL status_cleared got=%h want=%h", q_dmem, exp); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int v = 5; v <= 8; v++) begin
            drive(32'h1001, 32'(v), 1'b1);
            fifo_q.push_back(32'(v));
            tick();
        end
        out_ready = 1'b1;
        drive(32'h1001, 32'd9, 1'b1);
        exp = fifo_q.pop_front();
        total++; if (out_data !== exp) begin bad++; $display("FAIL full_pushpop_head got=%h want=%h", out_data, exp); end
        fifo_q.push_back(32'd9);
        tick();
        out_ready = 1'b0;
        drive(32'h1002, 32'd0, 1'b0);
        exp_q.push_back(32'h42);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL full_pushpop_status got=%h want=%h", q_dmem, exp); end
        out_ready = 1'b1;
        drive(32'h0000, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp = fifo_q.pop_front();
            total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL drain_full idx=%0d got=%b/%h want=1/%h", i, out_valid, out_data, exp); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_full_empty got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        drive(32'h0000, 32'h0000_A5A5, 1'b1);
        tick();
        drive(32'h2000, 32'd0, 1'b0);
        exp_q.push_back(32'd0);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL unmapped_load got=%h want=%h", q_dmem, exp); end
        drive(32'h2000, 32'hFFFF_FFFF, 1'b1);
        tick();
        drive(32'h0000, 32'd0, 1'b0);
        exp_q.push_back(32'h0000_A5A5);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL unmapped_store got=%h want=%h", q_dmem, exp); end
        drive(32'h0001_0005, 32'd0, 1'b0);
        exp_q.push_back(32'd0);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL full_decode got=%h want=%h", q_dmem, exp); end
    endtask

    task automatic test_cycle_wrap();
        @(negedge clock);
        drive(32'h1000, 32'd0, 1'b0);
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = exp_q.pop_front();
            total++; if (q_dmem !== exp) begin bad++; $display("FAIL cycle_wrap idx=%0d got=%h want=%h", i, q_dmem, exp); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            drive(32'h1001, 32'h31 + 32'(v), 1'b1);
            tick();
        end
        drive(32'h1001, 32'd0, 1'b0);
        exp_q.push_back(32'd0);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL txdata_load got=%h want=%h", q_dmem, exp); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'h31) begin bad++; $display("FAIL txdata_nopop got=%b/%h want=1/%h", out_valid, out_data, 32'h31); end
        #2;
        reset = 1'b1;
        drive(32'h0000, 32'h1234, 1'b1);
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin bad++; $display("FAIL async_reset_fifo got=%b/%h want=0/0", out_valid, out_data); end
        total++; if (q_dmem !== 32'd0) begin bad++; $display("FAIL async_reset_q got=%h want=0", q_dmem); end
        tick();
        tick();
        reset = 1'b0;
        drive(32'h1000, 32'd0, 1'b0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_q.pop_front();
            total++; if (q_dmem !== exp) begin bad++; $display("FAIL cycle_restart idx=%0d got=%h want=%h", i, q_dmem, exp); end
        end
        drive(32'h0000, 32'd0, 1'b0);
        exp_q.push_back(32'h0000_A5A5);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL ram_kept got=%h want=%h", q_dmem, exp); end
        drive(32'h1002, 32'd0, 1'b0);
        exp_q.push_back(32'h01);
        tick();
        exp = exp_q.pop_front();
        total++; if (q_dmem !== exp) begin bad++; $display("FAIL status_after_reset got=%h want=%h", q_dmem, exp); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        out_ready = 1'b0;
        drive(32'd0, 32'd0, 1'b0);
        test_reset();
        test_ram();
        test_same_edge();
        test_overflow();
        test_back_to_back();
        test_unmapped();
        test_cycle_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
